// File: rtl/gmii_rx_delimit_pkg.sv
// Shared frame-parser definitions: delimiter FSM encodings, GMII preamble/SFD
// byte values and the position of the head/tail marker in the 9-bit stream.
package gmii_rx_delimit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_FIRST   = 3'd2,
        ST_TRAN    = 3'd3,
        ST_DISCARD = 3'd4
    } delimit_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         MARKER_BIT    = 8;
    localparam int         LEN_W         = 11;

endpackage

// File: rtl/gmii_rx_delimit_stat_cnt16.sv
// 16-bit statistics counter; advances by one per i_inc pulse and wraps to zero.
module stat_cnt16 (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        i_inc,
    output logic [15:0] ov_cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ov_cnt = cnt_q;

endmodule

// File: rtl/gmii_rx_delimit.sv
// GMII receive delimiter: strips preamble/SFD and emits {marker, byte} with the
// marker set on the first and last byte; malformed, errored or oversize frames are dropped.
module gmii_rx_delimit
    import gmii_rx_delimit_pkg::*;
#(
    parameter int MAX_LEN = 2000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        i_gmii_rx_dv,
    input  logic        i_gmii_rx_er,
    input  logic [7:0]  iv_gmii_rxd,
    output logic        o_data_wr,
    output logic [8:0]  ov_data,
    output logic [15:0] ov_rx_frame_cnt,
    output logic [15:0] ov_rx_err_cnt,
    output logic [2:0]  ov_delimit_state
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    delimit_state_e   state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
    logic             head_q, head_d;
    logic             wr_q, wr_d;
    logic [8:0]       data_q, data_d;
    logic             frame_inc;
    logic             err_inc;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        len_cnt_d = len_cnt_q;
        head_d    = head_q;
        wr_d      = 1'b0;
        data_d    = '0;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_gmii_rx_dv) begin
                    if (!i_gmii_rx_er && iv_gmii_rxd == PREAMBLE_BYTE) begin
                        state_d = ST_PRE;
                    end else begin
                        state_d = ST_DISCARD;
                        err_inc = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (!i_gmii_rx_dv) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                end else if (!i_gmii_rx_er && iv_gmii_rxd == SFD_BYTE) begin
                    state_d   = ST_FIRST;
                    len_cnt_d = '0;
                end else if (i_gmii_rx_er || iv_gmii_rxd != PREAMBLE_BYTE) begin
                    state_d = ST_DISCARD;
                    err_inc = 1'b1;
                end
            end
            ST_FIRST: begin
                if (i_gmii_rx_er) begin
                    state_d = ST_DISCARD;
                    err_inc = 1'b1;
                end else if (!i_gmii_rx_dv) begin
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                end else begin
                    hold_d    = iv_gmii_rxd;
                    len_cnt_d = LEN_W'(1);
                    head_d    = 1'b1;
                    state_d   = ST_TRAN;
                end
            end
            ST_TRAN: begin
                // An abort never emits the held byte, so the splicer sees a gap with no tail.
                if (i_gmii_rx_er || (i_gmii_rx_dv && len_cnt_q >= MAX_LEN_C)) begin
                    state_d = ST_DISCARD;
                    err_inc = 1'b1;
                end else if (!i_gmii_rx_dv) begin
                    state_d = ST_IDLE;
                    if (len_cnt_q >= LEN_W'(2)) begin
                        wr_d      = 1'b1;
                        data_d    = {1'b1, hold_q};
                        frame_inc = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end else begin
                    wr_d      = 1'b1;
                    data_d    = {head_q, hold_q};
                    hold_d    = iv_gmii_rxd;
                    len_cnt_d = len_cnt_q + LEN_W'(1);
                    head_d    = 1'b0;
                end
            end
            ST_DISCARD: begin
                if (!i_gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            len_cnt_q <= '0;
            head_q    <= 1'b0;
            wr_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            len_cnt_q <= len_cnt_d;
            head_q    <= head_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
        end
    end

    stat_cnt16 u_frame_cnt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_inc   (frame_inc),
        .ov_cnt  (ov_rx_frame_cnt)
    );

    stat_cnt16 u_err_cnt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_inc   (err_inc),
        .ov_cnt  (ov_rx_err_cnt)
    );

    assign o_data_wr        = wr_q;
    assign ov_data          = data_q;
    assign ov_delimit_state = state_q;

endmodule

// File: tb/tb_gmii_rx_delimit.sv
// Directed bench for gmii_rx_delimit (MAX_LEN=64): drives GMII frames and checks
// the delimited stream, markers, latency and statistics counters.
module tb_gmii_rx_delimit;

    logic        clk_sys;
    logic        reset_n;
    logic        i_gmii_rx_dv;
    logic        i_gmii_rx_er;
    logic [7:0]  iv_gmii_rxd;
    logic        o_data_wr;
    logic [8:0]  ov_data;
    logic [15:0] ov_rx_frame_cnt;
    logic [15:0] ov_rx_err_cnt;
    logic [2:0]  ov_delimit_state;

    gmii_rx_delimit #(.MAX_LEN(64)) dut (
        .clk_sys          (clk_sys),
        .reset_n          (reset_n),
        .i_gmii_rx_dv     (i_gmii_rx_dv),
        .i_gmii_rx_er     (i_gmii_rx_er),
        .iv_gmii_rxd      (iv_gmii_rxd),
        .o_data_wr        (o_data_wr),
        .ov_data          (ov_data),
        .ov_rx_frame_cnt  (ov_rx_frame_cnt),
        .ov_rx_err_cnt    (ov_rx_err_cnt),
        .ov_delimit_state (ov_delimit_state)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [8:0] cap[$];
    int         first_idx;
    int         gaps;
    logic       prev_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cap();
        cap.delete();
        first_idx = -99;
        gaps      = 0;
        prev_wr   = 1'b0;
    endtask

    // One byte time: inputs are sampled on the next rising edge, outputs read 1 ns later.
    task automatic drive(input logic dv, input logic er, input logic [7:0] d, input int idx);
        i_gmii_rx_dv = dv;
        i_gmii_rx_er = er;
        iv_gmii_rxd  = d;
        @(posedge clk_sys);
        #1;
        if (o_data_wr) begin
            if (cap.size() == 0) first_idx = idx;
            if (!prev_wr && cap.size() != 0 && idx >= 0) gaps++;
            cap.push_back(ov_data);
        end
        prev_wr = o_data_wr;
    endtask

    task automatic send_frame(input int npre, input int bad_pre, input int n, input int start,
                              input int step, input int er_idx, input logic end_er, input int ifg);
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, (i == bad_pre) ? 8'h57 : 8'h55, -1);
        drive(1'b1, 1'b0, 8'hD5, -1);
        for (int i = 0; i < n; i++) drive(1'b1, i == er_idx, 8'(start + i * step), i);
        drive(1'b0, end_er, 8'h00, -2);
        for (int i = 1; i < ifg; i++) drive(1'b0, 1'b0, 8'h00, -2);
    endtask

    function automatic int count_marks();
        int m = 0;
        foreach (cap[i]) if (cap[i][8]) m++;
        return m;
    endfunction

    initial begin
        reset_n      = 1'b0;
        i_gmii_rx_dv = 1'b0;
        i_gmii_rx_er = 1'b0;
        iv_gmii_rxd  = 8'h00;
        clear_cap();
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_wr", 32'(o_data_wr), 32'h0);
        check("rst_data", 32'(ov_data), 32'h0);
        check("rst_frames", 32'(ov_rx_frame_cnt), 32'h0);
        check("rst_errs", 32'(ov_rx_err_cnt), 32'h0);
        check("rst_state", 32'(ov_delimit_state), 32'h0);
        reset_n = 1'b1;

        // 64-byte frame (exactly MAX_LEN) 0x00..0x3F
        clear_cap();
        send_frame(7, -1, 64, 8'h00, 1, -1, 1'b0, 2);
        check("f64_count", 32'(cap.size()), 32'd64);
        check("f64_head", 32'(cap[0]), 32'h100);
        check("f64_second", 32'(cap[1]), 32'h001);
        check("f64_tail", 32'(cap[63]), 32'h13F);
        check("f64_marks", 32'(count_marks()), 32'd2);
        check("f64_first_edge", 32'(first_idx), 32'd1);
        check("f64_gaps", 32'(gaps), 32'd0);
        check("f64_frames", 32'(ov_rx_frame_cnt), 32'd1);
        check("f64_errs", 32'(ov_rx_err_cnt), 32'd0);
        check("f64_state", 32'(ov_delimit_state), 32'd0);

        // rx_er on payload byte index 20
        clear_cap();
        send_frame(7, -1, 64, 8'h00, 1, 20, 1'b0, 2);
        check("er_count", 32'(cap.size()), 32'd19);
        check("er_last", 32'(cap[18]), 32'h012);
        check("er_marks", 32'(count_marks()), 32'd1);
        check("er_frames", 32'(ov_rx_frame_cnt), 32'd1);
        check("er_errs", 32'(ov_rx_err_cnt), 32'd1);

        // Runt: one payload byte
        clear_cap();
        send_frame(7, -1, 1, 8'hAA, 0, -1, 1'b0, 2);
        check("runt_count", 32'(cap.size()), 32'd0);
        check("runt_errs", 32'(ov_rx_err_cnt), 32'd2);

        // Minimum frame: two bytes AA, BB
        clear_cap();
        send_frame(7, -1, 2, 8'hAA, 8'h11, -1, 1'b0, 2);
        check("two_count", 32'(cap.size()), 32'd2);
        check("two_head", 32'(cap[0]), 32'h1AA);
        check("two_tail", 32'(cap[1]), 32'h1BB);
        check("two_frames", 32'(ov_rx_frame_cnt), 32'd2);

        // er with dv falling: abort, no tail
        clear_cap();
        send_frame(3, -1, 5, 8'h20, 1, -1, 1'b1, 2);
        check("erfall_count", 32'(cap.size()), 32'd4);
        check("erfall_last", 32'(cap[3]), 32'h023);
        check("erfall_frames", 32'(ov_rx_frame_cnt), 32'd2);
        check("erfall_errs", 32'(ov_rx_err_cnt), 32'd3);

        // Bad preamble byte 0x57, then a clean 10-byte frame
        clear_cap();
        send_frame(7, 3, 10, 8'h10, 1, -1, 1'b0, 2);
        check("badpre_count", 32'(cap.size()), 32'd0);
        check("badpre_errs", 32'(ov_rx_err_cnt), 32'd4);
        send_frame(7, -1, 10, 8'h10, 1, -1, 1'b0, 2);
        check("after_count", 32'(cap.size()), 32'd10);
        check("after_head", 32'(cap[0]), 32'h110);
        check("after_tail", 32'(cap[9]), 32'h119);
        check("after_frames", 32'(ov_rx_frame_cnt), 32'd3);

        // Oversize: 100 bytes with MAX_LEN=64
        clear_cap();
        send_frame(7, -1, 100, 8'h00, 1, -1, 1'b0, 2);
        check("big_count", 32'(cap.size()), 32'd63);
        check("big_last", 32'(cap[62]), 32'h03E);
        check("big_frames", 32'(ov_rx_frame_cnt), 32'd3);
        check("big_errs", 32'(ov_rx_err_cnt), 32'd5);

        // Two 60-byte frames with a one-cycle IFG
        clear_cap();
        send_frame(7, -1, 60, 8'h00, 1, -1, 1'b0, 1);
        send_frame(7, -1, 60, 8'h00, 1, -1, 1'b0, 1);
        check("b2b_count", 32'(cap.size()), 32'd120);
        check("b2b_marks", 32'(count_marks()), 32'd4);
        check("b2b_tail1", 32'(cap[59]), 32'h13B);
        check("b2b_head2", 32'(cap[60]), 32'h100);
        check("b2b_tail2", 32'(cap[119]), 32'h13B);
        check("b2b_frames", 32'(ov_rx_frame_cnt), 32'd5);

        // Third frame interrupted by reset
        clear_cap();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55, -1);
        drive(1'b1, 1'b0, 8'hD5, -1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), i);
        check("mid_wr", 32'(o_data_wr), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_wr", 32'(o_data_wr), 32'h0);
        check("mrst_data", 32'(ov_data), 32'h0);
        check("mrst_frames", 32'(ov_rx_frame_cnt), 32'h0);
        check("mrst_errs", 32'(ov_rx_err_cnt), 32'h0);
        check("mrst_state", 32'(ov_delimit_state), 32'h0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        clear_cap();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(8'h46 + i), i);
        check("post_state", 32'(ov_delimit_state), 32'd4);
        check("post_errs", 32'(ov_rx_err_cnt), 32'd1);
        drive(1'b0, 1'b0, 8'h00, -2);
        check("post_count", 32'(cap.size()), 32'd0);
        send_frame(7, -1, 4, 8'hC0, 1, -1, 1'b0, 2);
        check("post_fcount", 32'(cap.size()), 32'd4);
        check("post_head", 32'(cap[0]), 32'h1C0);
        check("post_tail", 32'(cap[3]), 32'h1C3);
        check("post_frames", 32'(ov_rx_frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
